// File: rtl/data_readout.sv
// ---------------------------------------------------------------------------
// data_readout
//
// Drains one depth bank of a frequency-indexed storage array into a
// ready/valid stream. A drain walks depth slots of the selected bank in the
// outer loop and all frequency indices in the inner loop, issuing one storage
// read per cycle while the 2-entry output FIFO has room for the reply.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start, bank       request to drain a bank (bank sampled on accepted start)
//   rd_en, rd_addr    storage read request, rd_addr = {depth slot, freq}
//   rd_data           storage read reply, valid one cycle after rd_en
//   m_tdata/m_tuser   stream word and its frequency index
//   m_tvalid/m_tready stream handshake
//   m_tlast           final word of the drain
//   busy              drain in progress
//   done              one-cycle pulse after the final word transferred
//   start_err         one-cycle pulse for a start received while busy
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; no reads issued
// RUN   | issuing reads, one per cycle when the FIFO has room
// FLUSH | last read issued; waiting for the last word to transfer
// ---------------------------------------------------------------------------
module data_readout #(
    parameter int DATA_WIDTH = 64,
    parameter int N_FREQ     = 128,
    parameter int DEPTH      = 32,
    parameter int N_BANK     = 2,
    localparam int FW        = (N_FREQ > 1) ? $clog2(N_FREQ) : 1,
    localparam int DW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BW        = (N_BANK > 1) ? $clog2(N_BANK) : 1,
    localparam int AW        = FW + DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BW-1:0]         bank,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [FW-1:0]         m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err
);

    localparam int BANK_SZ = DEPTH / N_BANK;
    localparam int SW      = (BANK_SZ > 1) ? $clog2(BANK_SZ) : 1;
    // FIFO entry layout: {last, freq, data}
    localparam int EW      = DATA_WIDTH + FW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [BW-1:0]   bank_q;
    logic [SW-1:0]   s_cnt;
    logic [FW-1:0]   f_cnt;

    // Read pipeline: tag travels with rd_en, then with the reply cycle.
    logic            rd_last_tag;
    logic            rd_vld;
    logic [FW-1:0]   vld_user;
    logic            vld_last;

    logic [EW-1:0]   fifo_q [2];
    logic [1:0]      fifo_cnt;

    // Combinational datapath
    logic [BW-1:0]   cur_bank;
    logic [SW-1:0]   cur_s;
    logic [FW-1:0]   cur_f;
    logic [DW-1:0]   cur_slot;
    logic            is_last;
    logic [EW-1:0]   incoming;
    logic [EW-1:0]   out_word;
    logic            head_valid;
    logic            xfer;
    logic            pop;
    logic            push;
    logic [1:0]      cnt_nxt;
    logic [2:0]      occ_nxt;
    logic            room;
    logic            issue;

    // On an accepted start the read position comes straight from the
    // request so the first read can be issued on the very same edge.
    always_comb begin
        if (state == IDLE) begin
            cur_bank = bank;
            cur_s    = '0;
            cur_f    = '0;
        end else begin
            cur_bank = bank_q;
            cur_s    = s_cnt;
            cur_f    = f_cnt;
        end
    end

    assign cur_slot = DW'(cur_bank) * DW'(BANK_SZ) + DW'(cur_s);
    assign is_last  = (cur_s == SW'(BANK_SZ - 1)) && (cur_f == FW'(N_FREQ - 1));

    assign incoming   = {vld_last, vld_user, rd_data};
    assign head_valid = (fifo_cnt != 2'd0);

    // An empty FIFO lets the reply bypass straight to the stream, which is
    // what gives one-cycle-per-word throughput and the two-cycle latency.
    // A bypassed word that is not taken is pushed, so the next cycle shows
    // the same word from the FIFO head.
    always_comb begin
        out_word = '0;
        if (head_valid) begin
            out_word = fifo_q[0];
        end else if (rd_vld) begin
            out_word = incoming;
        end
    end

    assign m_tvalid = head_valid | rd_vld;
    assign m_tdata  = out_word[DATA_WIDTH-1:0];
    assign m_tuser  = out_word[DATA_WIDTH +: FW];
    assign m_tlast  = out_word[EW-1];

    assign xfer    = m_tvalid & m_tready;
    assign pop     = xfer & head_valid;
    assign push    = rd_vld & ~(xfer & ~head_valid);
    assign cnt_nxt = fifo_cnt + 2'(push) - 2'(pop);

    // Next cycle the FIFO holds cnt_nxt words and the read issued this
    // cycle (rd_en) will return; a new read may only be issued if its reply
    // will also fit, so the two FIFO entries can never overflow.
    assign occ_nxt = 3'(cnt_nxt) + 3'(rd_en);
    assign room    = (occ_nxt < 3'd2);
    assign issue   = room && (((state == IDLE) && start) || (state == RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bank_q      <= '0;
            s_cnt       <= '0;
            f_cnt       <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_last_tag <= 1'b0;
            rd_vld      <= 1'b0;
            vld_user    <= '0;
            vld_last    <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            fifo_cnt    <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            // Output FIFO, shift-register style with the head in entry 0
            if (pop) begin
                fifo_q[0] <= (fifo_cnt == 2'd2) ? fifo_q[1] : incoming;
                if (push) begin
                    fifo_q[1] <= incoming;
                end
            end else if (push) begin
                if (fifo_cnt == 2'd0) begin
                    fifo_q[0] <= incoming;
                end else begin
                    fifo_q[1] <= incoming;
                end
            end
            fifo_cnt <= cnt_nxt;

            // Reply stage: storage answers one cycle after rd_en
            rd_vld   <= rd_en;
            vld_user <= rd_addr[FW-1:0];
            vld_last <= rd_last_tag;

            // Read issue and position counters
            rd_en <= issue;
            if (issue) begin
                rd_addr     <= {cur_slot, cur_f};
                rd_last_tag <= is_last;
                if (cur_f == FW'(N_FREQ - 1)) begin
                    f_cnt <= '0;
                    s_cnt <= is_last ? cur_s : cur_s + SW'(1);
                end else begin
                    f_cnt <= cur_f + FW'(1);
                    s_cnt <= cur_s;
                end
            end else if ((state == IDLE) && start) begin
                s_cnt <= '0;
                f_cnt <= '0;
            end

            done      <= 1'b0;
            start_err <= start && (state != IDLE);

            case (state)
                IDLE: begin
                    if (start) begin
                        bank_q <= bank;
                        busy   <= 1'b1;
                        state  <= (issue && is_last) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (issue && is_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (xfer && m_tlast) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_readout.sv
// ---------------------------------------------------------------------------
// tb_data_readout
//
// Directed bench for data_readout at default parameters (N_FREQ=128,
// DEPTH=32, N_BANK=2 -> 16 slots per bank, 2048 words per drain). A storage
// model answers every read one cycle later with a word derived from its
// address. run_drain drives one drain and records what it observes; each
// test task then compares the observations against hand-derived values.
// ---------------------------------------------------------------------------
module tb_data_readout;

    logic        clk;
    logic        rst;
    logic        start;
    logic [0:0]  bank;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic [63:0] m_tdata;
    logic [6:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        done;
    logic        start_err;

    int n_cmp = 0;
    int n_err = 0;

    // Observations from the most recent run_drain
    int          r_words, r_reads, r_bad_word, r_first_bad, r_bad_addr;
    int          r_first_rd, r_first_vld, r_last_rd, r_last_xfer, r_done_cyc;
    int          r_busy_at_done, r_stall_bad, r_err_pulses, r_timeout;
    int          r_stall_reads, r_tlast_cnt;
    logic [11:0] r_first_addr, r_last_addr;
    logic [63:0] r_stall_head;
    logic [6:0]  r_stall_user;
    logic        r_stall_valid;

    data_readout dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bank      (bank),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_tdata   (m_tdata),
        .m_tuser   (m_tuser),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy),
        .done      (done),
        .start_err (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [11:0] a);
        return {20'hC0FFE, a, 20'h13579, ~a};
    endfunction

    // Address of the k-th read of a drain of bank bnk: {bnk*16 + k/128, k%128}
    function automatic logic [11:0] exp_addr(input int bnk, input int k);
        int slot;
        slot = bnk * 16 + k / 128;
        return 12'(slot * 128 + (k % 128));
    endfunction

    // Storage model: reply one cycle after rd_en, junk otherwise
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem_word(rd_addr);
        else       rd_data <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // rmode: 100 = ready always, 50 = random, 0 = stalled for 100 cycles
    // err_at: word count at which a stray start is pulsed (-1 = never)
    // stop_at: return once this many words transferred (-1 = run to done)
    // chain: on the done cycle raise start for bank chain_bank and return
    task automatic run_drain(input int bnk, input int rmode, input int err_at,
                             input int stop_at, input bit do_start,
                             input bit chain, input int chain_bank);
        int          cyc, nw, nr;
        bit          err_sent, prev_v, prev_x, prev_l;
        logic [63:0] prev_d, ed;
        logic [6:0]  prev_u;
        r_bad_word = 0; r_first_bad = -1; r_bad_addr = 0; r_first_rd = -1;
        r_first_vld = -1; r_last_rd = -1; r_last_xfer = -1; r_done_cyc = -1;
        r_busy_at_done = -1; r_stall_bad = 0; r_err_pulses = 0; r_timeout = 1;
        r_stall_reads = 0; r_tlast_cnt = 0; r_first_addr = '1; r_last_addr = '1;
        r_stall_head = '0; r_stall_user = '0; r_stall_valid = 1'b0;
        err_sent = 0; prev_v = 0; prev_x = 0; prev_l = 0; prev_d = '0; prev_u = '0;
        if (do_start) begin
            start = 1'b1;
            bank  = 1'(bnk);
        end
        @(negedge clk);
        start = 1'b0;
        cyc = 0; nw = 0; nr = 0;
        while (cyc < 20000) begin
            if (stop_at >= 0 && nw >= stop_at) begin
                r_timeout = 0;
                break;
            end
            if (start_err) r_err_pulses++;
            if (done) begin
                r_done_cyc     = cyc;
                r_busy_at_done = int'(busy);
                r_timeout      = 0;
                if (chain) begin
                    start = 1'b1;
                    bank  = 1'(chain_bank);
                end
                break;
            end
            if (rd_en) begin
                if (r_first_rd < 0) begin
                    r_first_rd   = cyc;
                    r_first_addr = rd_addr;
                end
                r_last_rd   = cyc;
                r_last_addr = rd_addr;
                if (nr >= 2048 || rd_addr !== exp_addr(bnk, nr)) r_bad_addr++;
                nr++;
            end
            if (cyc < 100) r_stall_reads = nr;
            if (cyc == 99) begin
                r_stall_head  = m_tdata;
                r_stall_user  = m_tuser;
                r_stall_valid = m_tvalid;
            end
            if (m_tvalid && r_first_vld < 0) r_first_vld = cyc;
            if (prev_v && !prev_x) begin
                if (!m_tvalid || m_tdata !== prev_d || m_tuser !== prev_u || m_tlast !== prev_l)
                    r_stall_bad++;
            end
            if (start) start = 1'b0;
            if (err_at >= 0 && nw == err_at && !err_sent) begin
                start    = 1'b1;
                bank     = 1'(1 - bnk);
                err_sent = 1;
            end
            case (rmode)
                100:     m_tready = 1'b1;
                50:      m_tready = 1'($urandom_range(0, 1));
                default: m_tready = (cyc >= 100);
            endcase
            prev_x = m_tvalid && m_tready;
            if (prev_x) begin
                ed = mem_word(exp_addr(bnk, nw));
                if (nw >= 2048 || m_tdata !== ed || m_tuser !== 7'(nw % 128)
                    || m_tlast !== (nw == 2047)) begin
                    if (r_first_bad < 0) r_first_bad = nw;
                    r_bad_word++;
                end
                if (m_tlast) r_tlast_cnt++;
                r_last_xfer = cyc;
                nw++;
            end
            prev_v = m_tvalid; prev_d = m_tdata; prev_u = m_tuser; prev_l = m_tlast;
            @(negedge clk);
            cyc++;
        end
        r_words = nw;
        r_reads = nr;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bank = 1'b0; m_tready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
        n_cmp++; if (rd_addr !== 12'd0) begin n_err++; $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid: got %0b expected 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL reset_m_tlast: got %0b expected 0", m_tlast); end
        n_cmp++; if (m_tdata !== 64'd0) begin n_err++; $display("FAIL reset_m_tdata: got %0h expected 0", m_tdata); end
        n_cmp++; if (m_tuser !== 7'd0) begin n_err++; $display("FAIL reset_m_tuser: got %0h expected 0", m_tuser); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_cmp++; if (start_err !== 1'b0) begin n_err++; $display("FAIL reset_start_err: got %0b expected 0", start_err); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({rd_en, busy, m_tvalid} !== 3'b000) begin n_err++; $display("FAIL idle_quiet: got %03b expected 000", {rd_en, busy, m_tvalid}); end
    endtask

    task automatic test_full_ready;
        run_drain(1, 100, -1, -1, 1'b1, 1'b0, 0);
        n_cmp++; if (r_timeout !== 0) begin n_err++; $display("FAIL full_timeout: got %0d expected 0", r_timeout); end
        n_cmp++; if (r_words !== 2048) begin n_err++; $display("FAIL full_words: got %0d expected 2048", r_words); end
        n_cmp++; if (r_reads !== 2048) begin n_err++; $display("FAIL full_reads: got %0d expected 2048", r_reads); end
        n_cmp++; if (r_bad_addr !== 0) begin n_err++; $display("FAIL full_addr_order: got %0d bad expected 0", r_bad_addr); end
        n_cmp++; if (r_bad_word !== 0) begin n_err++; $display("FAIL full_words_data: got %0d bad (first %0d) expected 0", r_bad_word, r_first_bad); end
        n_cmp++; if (r_first_addr !== {5'd16, 7'd0}) begin n_err++; $display("FAIL full_first_addr: got %0h expected %0h", r_first_addr, {5'd16, 7'd0}); end
        n_cmp++; if (r_last_addr !== {5'd31, 7'd127}) begin n_err++; $display("FAIL full_last_addr: got %0h expected %0h", r_last_addr, {5'd31, 7'd127}); end
        n_cmp++; if (r_first_rd !== 0) begin n_err++; $display("FAIL full_rd_latency: got %0d expected 0", r_first_rd); end
        n_cmp++; if (r_first_vld !== 1) begin n_err++; $display("FAIL full_valid_latency: got %0d expected 1", r_first_vld); end
        n_cmp++; if (r_last_rd - r_first_rd !== 2047) begin n_err++; $display("FAIL full_rd_span: got %0d expected 2047", r_last_rd - r_first_rd); end
        n_cmp++; if (r_tlast_cnt !== 1) begin n_err++; $display("FAIL full_tlast_count: got %0d expected 1", r_tlast_cnt); end
        n_cmp++; if (r_done_cyc !== 2049) begin n_err++; $display("FAIL full_done_cycle: got %0d expected 2049", r_done_cyc); end
        n_cmp++; if (r_done_cyc - r_last_xfer !== 1) begin n_err++; $display("FAIL full_done_after_last: got %0d expected 1", r_done_cyc - r_last_xfer); end
        n_cmp++; if (r_busy_at_done !== 0) begin n_err++; $display("FAIL full_busy_at_done: got %0d expected 0", r_busy_at_done); end
    endtask

    task automatic test_random_ready;
        run_drain(0, 50, -1, -1, 1'b1, 1'b0, 0);
        n_cmp++; if (r_timeout !== 0) begin n_err++; $display("FAIL rand_timeout: got %0d expected 0", r_timeout); end
        n_cmp++; if (r_words !== 2048) begin n_err++; $display("FAIL rand_words: got %0d expected 2048", r_words); end
        n_cmp++; if (r_reads !== 2048) begin n_err++; $display("FAIL rand_reads: got %0d expected 2048", r_reads); end
        n_cmp++; if (r_bad_word !== 0) begin n_err++; $display("FAIL rand_words_data: got %0d bad (first %0d) expected 0", r_bad_word, r_first_bad); end
        n_cmp++; if (r_bad_addr !== 0) begin n_err++; $display("FAIL rand_addr_order: got %0d bad expected 0", r_bad_addr); end
        n_cmp++; if (r_stall_bad !== 0) begin n_err++; $display("FAIL rand_stall_stable: got %0d unstable expected 0", r_stall_bad); end
    endtask

    task automatic test_stall;
        run_drain(0, 0, -1, -1, 1'b1, 1'b0, 0);
        n_cmp++; if (r_stall_reads !== 2) begin n_err++; $display("FAIL stall_reads: got %0d expected 2", r_stall_reads); end
        n_cmp++; if (r_stall_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %0b expected 1", r_stall_valid); end
        n_cmp++; if (r_stall_head !== mem_word(12'd0)) begin n_err++; $display("FAIL stall_head_data: got %0h expected %0h", r_stall_head, mem_word(12'd0)); end
        n_cmp++; if (r_stall_user !== 7'd0) begin n_err++; $display("FAIL stall_head_user: got %0d expected 0", r_stall_user); end
        n_cmp++; if (r_stall_bad !== 0) begin n_err++; $display("FAIL stall_stable: got %0d unstable expected 0", r_stall_bad); end
        n_cmp++; if (r_words !== 2048) begin n_err++; $display("FAIL stall_words: got %0d expected 2048", r_words); end
        n_cmp++; if (r_bad_word !== 0) begin n_err++; $display("FAIL stall_words_data: got %0d bad (first %0d) expected 0", r_bad_word, r_first_bad); end
    endtask

    task automatic test_start_err;
        run_drain(1, 100, 500, -1, 1'b1, 1'b0, 0);
        n_cmp++; if (r_err_pulses !== 1) begin n_err++; $display("FAIL err_pulses: got %0d expected 1", r_err_pulses); end
        n_cmp++; if (r_words !== 2048) begin n_err++; $display("FAIL err_words: got %0d expected 2048", r_words); end
        n_cmp++; if (r_bad_word !== 0) begin n_err++; $display("FAIL err_bank_kept: got %0d bad (first %0d) expected 0", r_bad_word, r_first_bad); end
        n_cmp++; if (r_bad_addr !== 0) begin n_err++; $display("FAIL err_addr_order: got %0d bad expected 0", r_bad_addr); end
    endtask

    task automatic test_reset_mid;
        run_drain(0, 100, -1, 1000, 1'b1, 1'b0, 0);
        n_cmp++; if (r_timeout !== 0) begin n_err++; $display("FAIL rstmid_reach_1000: got timeout %0d expected 0", r_timeout); end
        n_cmp++; if (r_done_cyc !== -1) begin n_err++; $display("FAIL rstmid_no_early_done: got %0d expected -1", r_done_cyc); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL rstmid_rd_en: got %0b expected 0", rd_en); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_m_tvalid: got %0b expected 0", m_tvalid); end
        n_cmp++; if ({busy, done, start_err, m_tlast} !== 4'b0000) begin n_err++; $display("FAIL rstmid_flags: got %04b expected 0000", {busy, done, start_err, m_tlast}); end
        n_cmp++; if ({rd_addr, m_tuser, m_tdata} !== 83'd0) begin n_err++; $display("FAIL rstmid_buses: got %0h/%0h/%0h expected 0", rd_addr, m_tuser, m_tdata); end
        rst = 1'b0;
        run_drain(0, 100, -1, -1, 1'b1, 1'b0, 0);
        n_cmp++; if (r_first_addr !== 12'd0) begin n_err++; $display("FAIL rstmid_restart_addr: got %0h expected 0", r_first_addr); end
        n_cmp++; if (r_words !== 2048) begin n_err++; $display("FAIL rstmid_restart_words: got %0d expected 2048", r_words); end
        n_cmp++; if (r_bad_word !== 0) begin n_err++; $display("FAIL rstmid_restart_data: got %0d bad (first %0d) expected 0", r_bad_word, r_first_bad); end
        n_cmp++; if (r_done_cyc !== 2049) begin n_err++; $display("FAIL rstmid_restart_done: got %0d expected 2049", r_done_cyc); end
    endtask

    task automatic test_back_to_back;
        run_drain(1, 100, -1, -1, 1'b1, 1'b1, 0);
        n_cmp++; if (r_words !== 2048) begin n_err++; $display("FAIL b2b_first_words: got %0d expected 2048", r_words); end
        n_cmp++; if (r_done_cyc !== 2049) begin n_err++; $display("FAIL b2b_first_done: got %0d expected 2049", r_done_cyc); end
        run_drain(0, 100, -1, -1, 1'b0, 1'b0, 0);
        n_cmp++; if (r_first_rd !== 0) begin n_err++; $display("FAIL b2b_second_rd_gap: got %0d expected 0", r_first_rd); end
        n_cmp++; if (r_first_addr !== 12'd0) begin n_err++; $display("FAIL b2b_second_first_addr: got %0h expected 0", r_first_addr); end
        n_cmp++; if (r_err_pulses !== 0) begin n_err++; $display("FAIL b2b_no_start_err: got %0d expected 0", r_err_pulses); end
        n_cmp++; if (r_words !== 2048) begin n_err++; $display("FAIL b2b_second_words: got %0d expected 2048", r_words); end
        n_cmp++; if (r_bad_word !== 0) begin n_err++; $display("FAIL b2b_second_data: got %0d bad (first %0d) expected 0", r_bad_word, r_first_bad); end
        n_cmp++; if (r_done_cyc !== 2049) begin n_err++; $display("FAIL b2b_second_done: got %0d expected 2049", r_done_cyc); end
    endtask

    initial begin
        test_reset;
        test_full_ready;
        test_random_ready;
        test_stall;
        test_start_err;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
